// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling with overrun/frame errors.
// Ports: clk, rst, rx, rx_ready, err_clr -> rx_data, rx_valid, rx_busy, frame_err, overrun.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  rx_data_n;
  logic        rx_valid_n;
  logic        rx_busy_n;
  logic        frame_err_n;
  logic        overrun_n;
  logic        deliver;
  logic        rx_meta, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      rx_busy   <= rx_busy_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid;
    overrun_n   = overrun;
    frame_err_n = 1'b0;
    deliver     = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          // Start bit must still be low at mid-bit, else it was a glitch.
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      WAIT_HIGH: begin
        // A break holds the line low; wait it out so it flags only once.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (deliver) begin
      rx_data_n  = shreg;
      rx_valid_n = 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid_n = 1'b0;
    end

    // New overrun wins over a coincident clear.
    if (deliver && rx_valid && !rx_ready) begin
      overrun_n = 1'b1;
    end else if (err_clr) begin
      overrun_n = 1'b0;
    end

    rx_busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit.
// Each scenario task drives frames and checks outputs against hand values.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int         rise_cnt = 0;
  int         hi_cnt   = 0;
  int         fe_cnt   = 0;
  logic       prev_valid = 1'b0;
  logic       prev_busy  = 1'b0;
  logic       fell_at_rise = 1'b0;
  logic [7:0] cap [0:31];

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_ready (rx_ready),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    prev_busy  <= rx_busy;
    if (rx_valid && !prev_valid) begin
      cap[rise_cnt % 32] <= rx_data;
      fell_at_rise       <= prev_busy && !rx_busy;
      rise_cnt           <= rise_cnt + 1;
    end
    if (rx_valid)  hi_cnt <= hi_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rx_valid: got %b want 0", rx_valid);
    end
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rx_busy: got %b want 0", rx_busy);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_valid_frame();
    int r0, f0;
    r0 = rise_cnt;
    f0 = fe_cnt;
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_data: got %h want a5", rx_data);
    end
    n_checks++;
    if (rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_valid_held: got %b want 1", rx_valid);
    end
    n_checks++;
    if (rise_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL a5_rises: got %0d want 1", rise_cnt - r0);
    end
    n_checks++;
    if (fe_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL a5_frame_err: got %0d want 0", fe_cnt - f0);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_overrun: got %b want 0", overrun);
    end
    n_checks++;
    if (fell_at_rise !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_busy_fall: got %b want 1", fell_at_rise);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_consume: got %b want 0", rx_valid);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch();
    int r0, f0;
    r0 = rise_cnt;
    f0 = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_start: got %b want 1", rx_busy);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle: got %b want 0", rx_busy);
    end
    n_checks++;
    if (rise_cnt - r0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_valid: got %0d want 0", rise_cnt - r0);
    end
    n_checks++;
    if (fe_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    r0 = rise_cnt;
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fe_busy_low: got %b want 1", rx_busy);
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_valid: got %b want 0", rx_valid);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_busy_high: got %b want 0", rx_busy);
    end
    n_checks++;
    if (fe_cnt - f0 !== 1) begin
      n_fail++;
      $display("FAIL fe_pulses: got %0d want 1", fe_cnt - f0);
    end
    n_checks++;
    if (rise_cnt - r0 !== 0) begin
      n_fail++;
      $display("FAIL fe_rises: got %0d want 0", rise_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0, h0;
    r0 = rise_cnt;
    h0 = hi_cnt;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    rx_ready = 1'b0;
    n_checks++;
    if (rise_cnt - r0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_rises: got %0d want 2", rise_cnt - r0);
    end
    n_checks++;
    if (cap[r0 % 32] !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_first: got %h want 00", cap[r0 % 32]);
    end
    n_checks++;
    if (cap[(r0 + 1) % 32] !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_second: got %h want ff", cap[(r0 + 1) % 32]);
    end
    n_checks++;
    if (hi_cnt - h0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_pulse_len: got %0d want 2", hi_cnt - h0);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun();
    int r0;
    r0 = rise_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL ovr_data: got %h want 22", rx_data);
    end
    n_checks++;
    if (rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_valid: got %b want 1", rx_valid);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: got %b want 1", overrun);
    end
    n_checks++;
    if (rise_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL ovr_rises: got %0d want 1", rise_cnt - r0);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int r0;
    d = 8'h5A;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (10) @(negedge clk);
    end
    rx = d[4];
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_before: got %b want 1", rx_busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst_data: got %h want 00", rx_data);
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_valid: got %b want 0", rx_valid);
    end
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_busy: got %b want 0", rx_busy);
    end
    n_checks++;
    if ({frame_err, overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_rst_flags: got %b want 00", {frame_err, overrun});
    end
    repeat (5) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = d[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (25) @(negedge clk);
    n_checks++;
    if (rise_cnt - r0 !== 0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_valid: got %0d/%b want 0/0", rise_cnt - r0, rx_valid);
    end
    send_frame(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_data !== 8'h81) begin
      n_fail++;
      $display("FAIL mid_next_data: got %h want 81", rx_data);
    end
    n_checks++;
    if (rx_valid !== 1'b1 || rise_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL mid_next_valid: got %b/%0d want 1/1", rx_valid, rise_cnt - r0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_valid_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate.
REQ-003 SHALL derive localparams CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division) and HALF_BIT = CLKS_PER_BIT / 2; the bit counter SHALL be 16 bits wide.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 SHALL have port rx, input, 1, the asynchronous serial line (idle high, 8N1, LSB first).
REQ-007 SHALL have port rx_ready, input, 1, the consumer accepting the held byte.
REQ-008 SHALL have port err_clr, input, 1, a synchronous clear of the sticky overrun flag.
REQ-009 SHALL have port rx_data, output, 8, the last received byte.
REQ-010 SHALL have port rx_valid, output, 1, meaning rx_data holds an unconsumed byte.
REQ-011 SHALL have port rx_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun, output, 1, a sticky flag set when an unconsumed byte is overwritten.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1) to produce rx_s; the FSM SHALL use only rx_s.
REQ-015 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: when rx_s==0, SHALL go to START with cnt=0.
REQ-017 START: SHALL increment cnt; at cnt==HALF_BIT-1, SHALL go to DATA (cnt=0, bit_idx=0) if rx_s==0, else return to IDLE with no outputs changed (glitch rejection).
REQ-018 DATA: SHALL increment cnt; at cnt==CLKS_PER_BIT-1, SHALL set cnt=0, shift rx_s into the shift register MSB while shifting right, and increment bit_idx; after the 8th sample (bit_idx==7), SHALL go to STOP.
REQ-019 STOP: at cnt==CLKS_PER_BIT-1, if rx_s==1, SHALL load rx_data with the shift register, set rx_valid, and go to IDLE.
REQ-020 STOP: at cnt==CLKS_PER_BIT-1, if rx_s==0, SHALL pulse frame_err for exactly 1 cycle, discard the byte (rx_data and rx_valid unchanged), and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: SHALL go to IDLE only when rx_s==1, so that a break or stuck-low line produces exactly one frame_err.
REQ-022 SHALL clear rx_valid on a cycle with rx_valid && rx_ready and no simultaneous delivery.
REQ-023 On a delivery cycle while rx_valid==1 and rx_ready==0, SHALL overwrite rx_data with the new byte, keep rx_valid=1, and set overrun.
REQ-024 On a delivery cycle with rx_valid && rx_ready, SHALL treat the old byte as consumed, present the new byte with rx_valid=1, and leave overrun unchanged.
REQ-025 SHALL clear overrun on err_clr; if err_clr coincides with a new overrun event, the set SHALL win.
REQ-026 Latency: rx_valid SHALL rise on the clock edge that samples the stop bit, about 9.5 bit times after the start edge plus 2 synchronizer cycles; all outputs SHALL be registered.
REQ-027 rx_busy SHALL be 1 in START, DATA, STOP and WAIT_HIGH.
REQ-028 SHALL ignore rx_ready while rx_valid==0.
REQ-029 SHALL never change rx_data except on a valid delivery.

Reset
REQ-030 On rst, SHALL asynchronously set state=IDLE, cnt=0, bit_idx=0, shift register=0x00, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, and both synchronizer flops=1.
REQ-031 After rst deasserts mid-frame, the remainder of that frame SHALL NOT produce rx_valid; reception SHALL restart on the next falling edge seen in IDLE.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10)
REQ-032 Send 0xA5 as a valid frame with rx_ready=0 -> rx_data=0xA5, rx_valid=1 held; frame_err=0; overrun=0; rx_busy falls in the same cycle rx_valid rises.
REQ-033 Drive rx low for 3 clk cycles, then high -> FSM returns to IDLE; no rx_valid; no frame_err.
REQ-034 Send 0x3C with the stop bit driven low and rx held low for 30 more cycles -> exactly one frame_err pulse; rx_valid=0; rx_busy stays 1 until rx returns high.
REQ-035 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22, rx_valid=1, overrun=1; pulse err_clr -> overrun=0.
REQ-036 Send 0x00 and 0xFF back-to-back with rx_ready=1 -> two one-cycle rx_valid pulses carrying 0x00 then 0xFF; overrun=0.
REQ-037 Assert rst during bit 4 of 0x5A -> all outputs at their reset values immediately; no rx_valid for that frame; a following 0x81 is received correctly.
